apb_controller_fsm: RTL and testbench

- Downstream stage of the AHB-to-APB bridge. Consumes the decoded and pipelined AHB transfer from the AHB slave interface: valid, address/data pipeline registers, write flag and tempselx.
- Sequences APB SETUP/ACCESS phases on Pselx/Penable/Paddr/Pwrite/Pwdata.
- Drives Hreadyout back to the AHB master to stall it while an APB transfer is in flight.
- Supports single reads, single writes, and back-to-back (pipelined) writes.

---
 rtl/apb_bridge_pkg.sv | 30 +++
 rtl/apb_controller_fsm.sv | 137 +++++++++++++
 tb/tb_apb_controller_fsm.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM state encoding,
// HTRANS codes and the APB slave address map.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
  localparam logic [31:0] SLV_LIMIT = 32'h8C00_0000;

  function automatic logic addr_in_range(input logic [31:0] addr);
    return (addr >= SLV0_BASE) && (addr < SLV_LIMIT);
  endfunction

endpackage

// File: rtl/apb_controller_fsm.sv
// APB sequencer of the AHB-to-APB bridge: turns pipelined AHB transfers into
// APB SETUP/ACCESS phases and stalls the AHB master through Hreadyout.
module apb_controller_fsm
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [ADDR_W-1:0] Haddr2,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Hwdata1,
  input  logic              Hwrite,
  input  logic              Hwritereg,
  input  logic [NSLV-1:0]   tempselx,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout
);

  state_t              state;
  state_t              next_state;
  logic [NSLV-1:0]     nxt_pselx;
  logic                nxt_penable;
  logic                nxt_pwrite;
  logic [ADDR_W-1:0]   nxt_paddr;
  logic [DATA_W-1:0]   nxt_pwdata;
  logic                nxt_hreadyout;

  // Next-state selection
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (!valid)      next_state = ST_IDLE;
        else if (Hwrite) next_state = ST_WWAIT;
        else             next_state = ST_READ;
      end
      ST_WWAIT:  next_state = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:   next_state = ST_RENABLE;
      ST_WRITE:  next_state = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP: next_state = ST_WENABLEP;
      ST_WENABLEP: begin
        if (!Hwritereg) next_state = ST_READ;
        else if (valid) next_state = ST_WRITEP;
        else            next_state = ST_WRITE;
      end
      default:   next_state = ST_IDLE;
    endcase
  end

  // Output values to be loaded alongside the state update
  always_comb begin
    nxt_pselx     = Pselx;
    nxt_penable   = Penable;
    nxt_pwrite    = Pwrite;
    nxt_paddr     = Paddr;
    nxt_pwdata    = Pwdata;
    nxt_hreadyout = Hreadyout;
    case (state)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (valid && !Hwrite) begin
          nxt_paddr     = Haddr;
          nxt_pwrite    = 1'b0;
          nxt_pselx     = tempselx;
          nxt_penable   = 1'b0;
          nxt_hreadyout = 1'b0;
        end else begin
          nxt_pselx     = {NSLV{1'b0}};
          nxt_penable   = 1'b0;
          nxt_hreadyout = 1'b1;
        end
      end
      ST_WWAIT: begin
        nxt_paddr     = Haddr1;
        nxt_pwdata    = Hwdata;
        nxt_pwrite    = 1'b1;
        nxt_pselx     = tempselx;
        nxt_penable   = 1'b0;
        nxt_hreadyout = 1'b0;
      end
      ST_READ, ST_WRITE, ST_WRITEP: begin
        nxt_penable   = 1'b1;
        nxt_hreadyout = 1'b1;
      end
      ST_WENABLEP: begin
        // The pending transfer may be the read that followed a write burst,
        // so direction comes from the latched write flag.
        nxt_paddr     = Haddr2;
        nxt_pwrite    = Hwritereg;
        nxt_pselx     = tempselx;
        nxt_penable   = 1'b0;
        nxt_hreadyout = 1'b0;
        if (Hwritereg) nxt_pwdata = Hwdata1;
        else           nxt_pwdata = Pwdata;
      end
      default: begin
        nxt_pselx     = {NSLV{1'b0}};
        nxt_penable   = 1'b0;
        nxt_pwrite    = 1'b0;
        nxt_paddr     = {ADDR_W{1'b0}};
        nxt_pwdata    = {DATA_W{1'b0}};
        nxt_hreadyout = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      Pselx     <= {NSLV{1'b0}};
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= {ADDR_W{1'b0}};
      Pwdata    <= {DATA_W{1'b0}};
      Hreadyout <= 1'b1;
    end else begin
      state     <= next_state;
      Pselx     <= nxt_pselx;
      Penable   <= nxt_penable;
      Pwrite    <= nxt_pwrite;
      Paddr     <= nxt_paddr;
      Pwdata    <= nxt_pwdata;
      Hreadyout <= nxt_hreadyout;
    end
  end

endmodule

// File: tb/tb_apb_controller_fsm.sv
// Directed bench for apb_controller_fsm: reset, single read/write,
// back-to-back writes, write-then-read and out-of-range traffic.
module tb_apb_controller_fsm;
  import apb_bridge_pkg::*;

  logic        Hclk;
  logic        Hresetn;
  logic        valid;
  logic [31:0] Haddr, Haddr1, Haddr2;
  logic [31:0] Hwdata, Hwdata1;
  logic        Hwrite, Hwritereg;
  logic [2:0]  tempselx;
  logic [2:0]  Pselx;
  logic        Penable, Pwrite, Hreadyout;
  logic [31:0] Paddr, Pwdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic prev_pen;

  apb_controller_fsm #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid),
    .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2),
    .Hwdata(Hwdata), .Hwdata1(Hwdata1),
    .Hwrite(Hwrite), .Hwritereg(Hwritereg), .tempselx(tempselx),
    .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Hreadyout(Hreadyout)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  // Tick while also confirming Penable is never high on two consecutive cycles
  task automatic tick_pen(input string tag);
    prev_pen = Penable;
    tick();
    check(tag, {63'd0, prev_pen & Penable}, 64'd0);
  endtask

  initial begin
    Hresetn = 1'b0; valid = 1'b0; Hwrite = 1'b0; Hwritereg = 1'b0;
    Haddr = 32'd0; Haddr1 = 32'd0; Haddr2 = 32'd0;
    Hwdata = 32'd0; Hwdata1 = 32'd0; tempselx = 3'b000;

    // Reset state
    tick(); tick();
    check("rst_psel", Pselx, 3'b000);
    check("rst_pen", Penable, 1'b0);
    check("rst_pwrite", Pwrite, 1'b0);
    check("rst_paddr", Paddr, 32'd0);
    check("rst_pwdata", Pwdata, 32'd0);
    check("rst_hready", Hreadyout, 1'b1);
    check("rst_state", dut.state, ST_IDLE);
    Hresetn = 1'b1;

    // Out-of-range address never leaves IDLE
    Haddr = 32'h9000_0000; valid = 1'b0; tempselx = 3'b000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("oor_psel", Pselx, 3'b000);
      check("oor_hready", Hreadyout, 1'b1);
      check("oor_state", dut.state, ST_IDLE);
    end

    // Single read
    valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0010; tempselx = 3'b001;
    tick();
    valid = 1'b0; Haddr = 32'd0; Haddr1 = 32'h8000_0010; tempselx = 3'b000;
    check("rd_setup_psel", Pselx, 3'b001);
    check("rd_setup_paddr", Paddr, 32'h8000_0010);
    check("rd_setup_pwrite", Pwrite, 1'b0);
    check("rd_setup_pen", Penable, 1'b0);
    check("rd_setup_hready", Hreadyout, 1'b0);
    check("rd_setup_state", dut.state, ST_READ);
    tick();
    check("rd_acc_pen", Penable, 1'b1);
    check("rd_acc_hready", Hreadyout, 1'b1);
    check("rd_acc_psel", Pselx, 3'b001);
    tick();
    check("rd_end_psel", Pselx, 3'b000);
    check("rd_end_pen", Penable, 1'b0);
    check("rd_end_state", dut.state, ST_IDLE);

    // Single write
    valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0004; tempselx = 3'b010;
    tick();
    check("wr_wwait_state", dut.state, ST_WWAIT);
    check("wr_wwait_psel", Pselx, 3'b000);
    check("wr_wwait_hready", Hreadyout, 1'b1);
    valid = 1'b0; Hwrite = 1'b0; Haddr = 32'd0; Haddr1 = 32'h8400_0004;
    Hwdata = 32'hDEAD_BEEF; Hwritereg = 1'b1;
    tick();
    check("wr_setup_psel", Pselx, 3'b010);
    check("wr_setup_paddr", Paddr, 32'h8400_0004);
    check("wr_setup_pwdata", Pwdata, 32'hDEAD_BEEF);
    check("wr_setup_pwrite", Pwrite, 1'b1);
    check("wr_setup_pen", Penable, 1'b0);
    check("wr_setup_hready", Hreadyout, 1'b0);
    check("wr_setup_state", dut.state, ST_WRITE);
    tick();
    check("wr_acc_pen", Penable, 1'b1);
    check("wr_acc_hready", Hreadyout, 1'b1);
    check("wr_acc_pwdata", Pwdata, 32'hDEAD_BEEF);
    tick();
    check("wr_end_psel", Pselx, 3'b000);
    check("wr_end_state", dut.state, ST_IDLE);

    // Back-to-back writes
    valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8800_0000; tempselx = 3'b100; Hwritereg = 1'b0;
    tick_pen("b2b_pen_a");
    Haddr = 32'h8800_0004; Haddr1 = 32'h8800_0000; Hwdata = 32'h0000_0011; Hwritereg = 1'b1;
    tick_pen("b2b_pen_b");
    check("b2b_w1_state", dut.state, ST_WRITEP);
    check("b2b_w1_paddr", Paddr, 32'h8800_0000);
    check("b2b_w1_pwdata", Pwdata, 32'h0000_0011);
    check("b2b_w1_psel", Pselx, 3'b100);
    check("b2b_w1_pwrite", Pwrite, 1'b1);
    check("b2b_w1_hready", Hreadyout, 1'b0);
    valid = 1'b0; Hwrite = 1'b0; Haddr = 32'd0; Haddr1 = 32'h8800_0004; Haddr2 = 32'h8800_0000;
    Hwdata = 32'h0000_0022; Hwdata1 = 32'h0000_0011;
    tick_pen("b2b_pen_c");
    check("b2b_w1acc_state", dut.state, ST_WENABLEP);
    check("b2b_w1acc_pen", Penable, 1'b1);
    check("b2b_w1acc_paddr", Paddr, 32'h8800_0000);
    Haddr1 = 32'd0; Haddr2 = 32'h8800_0004; Hwdata = 32'd0; Hwdata1 = 32'h0000_0022;
    tick_pen("b2b_pen_d");
    check("b2b_w2_state", dut.state, ST_WRITE);
    check("b2b_w2_paddr", Paddr, 32'h8800_0004);
    check("b2b_w2_pwdata", Pwdata, 32'h0000_0022);
    check("b2b_w2_pen", Penable, 1'b0);
    check("b2b_w2_hready", Hreadyout, 1'b0);
    tick_pen("b2b_pen_e");
    check("b2b_w2acc_pen", Penable, 1'b1);
    check("b2b_w2acc_paddr", Paddr, 32'h8800_0004);
    tick_pen("b2b_pen_f");
    check("b2b_end_psel", Pselx, 3'b000);
    check("b2b_end_state", dut.state, ST_IDLE);

    // Write followed by read
    valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8000_0008; tempselx = 3'b001; Hwritereg = 1'b0;
    tick();
    Hwrite = 1'b0; Haddr = 32'h8400_000C; Haddr1 = 32'h8000_0008; Hwdata = 32'h0000_0033;
    tempselx = 3'b010; Hwritereg = 1'b1;
    tick();
    check("wr_rd_w_state", dut.state, ST_WRITEP);
    check("wr_rd_w_paddr", Paddr, 32'h8000_0008);
    check("wr_rd_w_pwdata", Pwdata, 32'h0000_0033);
    valid = 1'b0; Haddr = 32'd0; Haddr1 = 32'h8400_000C; Haddr2 = 32'h8000_0008;
    Hwdata1 = 32'h0000_0033; Hwritereg = 1'b0;
    tick();
    check("wr_rd_wacc_pen", Penable, 1'b1);
    Haddr2 = 32'h8400_000C;
    tick();
    check("wr_rd_r_state", dut.state, ST_READ);
    check("wr_rd_r_pwrite", Pwrite, 1'b0);
    check("wr_rd_r_paddr", Paddr, 32'h8400_000C);
    check("wr_rd_r_psel", Pselx, 3'b010);
    check("wr_rd_r_pen", Penable, 1'b0);
    check("wr_rd_r_hready", Hreadyout, 1'b0);
    tick();
    check("wr_rd_racc_state", dut.state, ST_RENABLE);
    check("wr_rd_racc_pen", Penable, 1'b1);
    tick();
    check("wr_rd_end_state", dut.state, ST_IDLE);

    // Reset held mid-write
    valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0000; tempselx = 3'b010; Hwritereg = 1'b0;
    tick();
    valid = 1'b0; Hwrite = 1'b0; Haddr1 = 32'h8400_0000; Hwdata = 32'h0000_0055; Hwritereg = 1'b1;
    tick();
    check("mid_rst_pre_state", dut.state, ST_WRITE);
    Hresetn = 1'b0;
    tick();
    check("mid_rst1_psel", Pselx, 3'b000);
    check("mid_rst1_hready", Hreadyout, 1'b1);
    tick();
    check("mid_rst2_psel", Pselx, 3'b000);
    check("mid_rst2_pen", Penable, 1'b0);
    check("mid_rst2_hready", Hreadyout, 1'b1);
    check("mid_rst2_paddr", Paddr, 32'd0);
    check("mid_rst2_pwdata", Pwdata, 32'd0);
    check("mid_rst2_state", dut.state, ST_IDLE);
    Hresetn = 1'b1;
    tick();
    check("post_rst_state", dut.state, ST_IDLE);
    check("post_rst_pen", Penable, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
